// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration loader: frame sizing helpers and FSM states.
// Imported by the top and by the shadow register.
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int calc_cbits(input int w, input int n_in, input int n_out);
    return w * (n_in + n_out);
  endfunction

  function automatic int calc_nwords(input int cbits, input int cw);
    return (cbits + cw - 1) / cw;
  endfunction

  // A single-word frame still needs a one-bit index so that port widths stay legal.
  function automatic int calc_idxw(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/config_shadow_reg.sv
// CBITS-wide shadow register with word-indexed writes, clear, and commit to the output register.
// Bits of the last word that fall beyond CBITS are never stored.
module config_shadow_reg
  import config_loader_pkg::*;
#(
  parameter int CBITS = 30,
  parameter int CW    = 8,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDXW-1:0]  i_idx,
  input  logic [CW-1:0]    i_data,
  input  logic             i_commit,
  output logic [CBITS-1:0] o_c
);

  logic [CBITS-1:0] r_shadow;
  logic [CBITS-1:0] r_c;
  logic [CBITS-1:0] w_sel;
  logic [CBITS-1:0] w_bit;

  // Each shadow bit knows statically which word and which word bit feed it.
  for (genvar b = 0; b < CBITS; b++) begin : g_bit
    localparam int K = b / CW;
    localparam int J = b % CW;
    assign w_sel[b] = i_we && (i_idx == IDXW'(K));
    assign w_bit[b] = i_data[J];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (i_clr) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= (r_shadow & ~w_sel) | (w_bit & w_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c <= '0;
    end else if (i_commit) begin
      r_c <= r_shadow;
    end
  end

  assign o_c = r_c;

endmodule

// File: rtl/config_loader.sv
// Streams a configuration frame of NWORDS words into a shadow register and commits it atomically to c.
// States:  IDLE   | waiting for cfg_start
//          LOAD   | accepting words, cfg_ready high
//          COMMIT | one cycle; c <= shadow on the exit edge
module config_loader
  import config_loader_pkg::*;
#(
  parameter  int W          = 6,
  parameter  int EXTDATAIN  = 2,
  parameter  int EXTDATAOUT = 3,
  parameter  int CW         = 8,
  localparam int CBITS      = calc_cbits(W, EXTDATAIN, EXTDATAOUT),
  localparam int NWORDS     = calc_nwords(CBITS, CW),
  localparam int IDXW       = calc_idxw(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CW-1:0]    cfg_data,
  output logic             cfg_ready,
  output logic [CBITS-1:0] c,
  output logic             busy,
  output logic             cfg_done
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] w_cnt_nxt;
  logic            r_done;
  logic            w_clr;
  logic            w_we;
  logic            w_commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_commit;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_we        = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      ST_LOAD: begin
        // A restart wins over a word arriving in the same cycle.
        if (cfg_start) begin
          w_cnt_nxt = '0;
          w_clr     = 1'b1;
        end else if (cfg_valid) begin
          w_we = 1'b1;
          if (r_cnt == IDXW'(NWORDS - 1)) begin
            w_state_nxt = ST_COMMIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IDXW'(1);
          end
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  config_shadow_reg #(
    .CBITS (CBITS),
    .CW    (CW),
    .IDXW  (IDXW)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_we     (w_we),
    .i_idx    (r_cnt),
    .i_data   (cfg_data),
    .i_commit (w_commit),
    .o_c      (c)
  );

  assign cfg_ready = (r_state == ST_LOAD);
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_COMMIT);
  assign cfg_done  = r_done;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: directed frames plus random traffic, checked every cycle
// against a frame-level model that packs accepted words with plain arithmetic.
module tb_config_loader;

  localparam int CW     = 8;
  localparam int CBITS  = 6 * (2 + 3);
  localparam int NWORDS = (CBITS + CW - 1) / CW;

  logic             clk;
  logic             reset;
  logic             cfg_start;
  logic             cfg_valid;
  logic [CW-1:0]    cfg_data;
  logic             cfg_ready;
  logic [CBITS-1:0] c;
  logic             busy;
  logic             cfg_done;

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase (0 idle, 1 loading, 2 committing), accepted words, outputs.
  int               m_phase;
  logic [CW-1:0]    m_words[$];
  logic [CBITS-1:0] m_c;
  logic             m_done;

  config_loader dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .c         (c),
    .busy      (busy),
    .cfg_done  (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [CBITS-1:0] pack_frame();
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < m_words.size(); k++)
      acc = acc | (64'(m_words[k]) << (CW * k));
    return acc[CBITS-1:0];
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic vl, input logic [CW-1:0] d);
    if (rst) begin
      m_phase = 0;
      m_words.delete();
      m_c     = '0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (st) begin
             m_phase = 1;
             m_words.delete();
           end
        1: if (st) begin
             m_words.delete();
           end else if (vl) begin
             m_words.push_back(d);
             if (m_words.size() == NWORDS) m_phase = 2;
           end
        default: begin
          m_c     = pack_frame();
          m_done  = 1'b1;
          m_phase = 0;
        end
      endcase
    end
  endtask

  // One clock: drive on the falling edge, advance model after the rising edge, compare.
  task automatic cyc(input logic rst, input logic st, input logic vl, input logic [CW-1:0] d);
    @(negedge clk);
    reset     = rst;
    cfg_start = st;
    cfg_valid = vl;
    cfg_data  = d;
    @(posedge clk);
    #1;
    model_step(rst, st, vl, d);
    chk("c",         64'(c),         64'(m_c));
    chk("busy",      64'(busy),      64'(m_phase != 0));
    chk("cfg_ready", 64'(cfg_ready), 64'(m_phase == 1));
    chk("cfg_done",  64'(cfg_done),  64'(m_done));
  endtask

  task automatic send_frame(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                            input logic [CW-1:0] w2, input logic [CW-1:0] w3);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, w0);
    cyc(0, 0, 1, w1);
    cyc(0, 0, 1, w2);
    cyc(0, 0, 1, w3);
  endtask

  initial begin
    logic [CW-1:0] tw[4];
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    m_phase = 0; m_c = '0; m_done = 1'b0;

    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'hEE);
    chk("reset_c", 64'(c), 64'h0);

    // Nominal frame: commit lands two edges after the last word.
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h0F);
    chk("nominal_busy_commit", 64'(busy), 64'h1);
    chk("nominal_c_held", 64'(c), 64'h0);
    cyc(0, 0, 0, 8'h00);
    chk("nominal_c", 64'(c), 64'h0FFF3CA5);
    chk("nominal_done", 64'(cfg_done), 64'h1);
    cyc(0, 0, 0, 8'h00);
    chk("nominal_done_pulse", 64'(cfg_done), 64'h0);

    // Padding: top word 0xFF only fills the six live bits.
    send_frame(8'h00, 8'h00, 8'h00, 8'hFF);
    cyc(0, 0, 0, 8'h00);
    chk("pad_top", 64'(c[CBITS-1:24]), 64'h3F);
    chk("pad_c", 64'(c), 64'h3F000000);

    // Throttled source with junk data on idle cycles.
    tw[0] = 8'hA5; tw[1] = 8'h3C; tw[2] = 8'hFF; tw[3] = 8'h0F;
    cyc(0, 1, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, tw[k]);
      if (k < 3) cyc(0, 0, 0, 8'($urandom));
    end
    cyc(0, 0, 0, 8'h00);
    chk("throttle_c", 64'(c), 64'h0FFF3CA5);

    // Restart mid-frame, with a word on the restart cycle that must be dropped.
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h22);
    cyc(0, 1, 1, 8'h99);
    chk("restart_c_held", 64'(c), 64'h0FFF3CA5);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 8'(k));
    cyc(0, 0, 0, 8'h00);
    chk("restart_c", 64'(c), 64'h04030201);

    // Reset mid-LOAD after a good commit.
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h0F);
    cyc(0, 0, 0, 8'h00);
    chk("pre_reset_c", 64'(c), 64'h0FFF3CA5);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h55);
    cyc(0, 0, 1, 8'h66);
    cyc(1, 1, 1, 8'h77);
    chk("midreset_c", 64'(c), 64'h0);
    chk("midreset_busy", 64'(busy), 64'h0);
    chk("midreset_ready", 64'(cfg_ready), 64'h0);
    chk("midreset_done", 64'(cfg_done), 64'h0);

    // Out-of-frame: valid in IDLE, start during COMMIT.
    cyc(0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 8'($urandom));
    chk("idle_valid_c", 64'(c), 64'h0);
    send_frame(8'h12, 8'h34, 8'h56, 8'h78);
    cyc(0, 1, 1, 8'hAB);
    chk("commit_start_c", 64'(c), 64'h38563412);
    chk("commit_start_busy", 64'(busy), 64'h0);
    cyc(0, 0, 1, 8'hCD);
    chk("commit_start_idle", 64'(busy), 64'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
          1'($urandom), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
